trap_unit: RTL and testbench
============================

// Module: trap_unit
// PURPOSE
//  Machine-mode trap/CSR controller downstream of the main decoder. Consumes the decoder's
//  exceptSignal/trapReturn/csrWriteEnable for the decode-stage instruction and owns mstatus,
//  mtvec, mepc, mcause, mscratch (mtval optional). Sequences trap entry and mret: updates CSRs,
//  flushes the pipe and redirects fetch. Feeds privMode back to the decoder.
// PARAMETERS
//  XLEN          64     datapath/CSR width
//  RESET_MTVEC   'h0    mtvec reset value (direct mode, bits[1:0] forced 0)
//  DRAIN_CYCLES  2      cycles after redirect during which new events are ignored (1..15)
// PORTS
//  clk               in   1     single clock, rising edge
//  reset_n           in   1     asynchronous, active-low reset
//  coprocessorStall  in   1     freeze: no state/CSR change while high
//  id_valid          in   1     decode-stage instruction is valid
//  id_pc             in   XLEN  PC of decode-stage instruction
//  id_instr          in   32    raw instruction (mtval source)
//  exceptSignal      in   3     [2] illegal, [1] ecall, [0] ebreak
//  trapReturn        in   1     mret decoded
//  csrWriteEnable    in   1     CSR instruction writes csr_addr
//  csr_addr          in   12    CSR address (funct12)
//  csr_wdata         in   XLEN  final value to write (set/clear resolved by ALU)
//  csr_rdata         out  XLEN  combinational read of csr_addr; 0 if unimplemented
//  privMode          out  2     current privilege (11 M, 00 U)
//  redirect_valid    out  1     one-cycle fetch redirect strobe
//  redirect_pc       out  XLEN  redirect target, valid with redirect_valid
//  flush             out  1     kill IF/ID/EX younger instructions; coincident with redirect_valid
// BEHAVIOUR
//  Reset: privMode=11, mstatus=0, mtvec=RESET_MTVEC&~3, mepc=mcause=mscratch=mtval=0,
//   redirect_valid=0, redirect_pc=0, flush=0, FSM=IDLE.
//  Event = id_valid & (|exceptSignal | trapReturn), sampled only in IDLE and !coprocessorStall.
//  Priority: illegal > ecall > ebreak > mret. mret with privMode!=11 is treated as illegal.
//  Causes: illegal=2, ebreak=3, ecall = 8 (U) / 11 (M).
//  FSM IDLE -> REDIRECT -> DRAIN -> IDLE.
//   IDLE, event at edge N: trap: mepc<=id_pc, mcause<=cause, MPIE<=MIE, MIE<=0, MPP<=privMode,
//    privMode<=11, redirect_pc<={mtvec[XLEN-1:2],2'b00}. mret: privMode<=MPP, MIE<=MPIE, MPIE<=1,
//    MPP<=00, redirect_pc<=mepc. State->REDIRECT.
//   REDIRECT (cycle N+1): redirect_valid=1, flush=1 for exactly one cycle; -> DRAIN.
//   DRAIN: counter loads DRAIN_CYCLES, decrements; events/CSR writes ignored; at 0 -> IDLE.
//   DRAIN_CYCLES=0 is out of range (DRAIN always lasts >=1 cycle).
//  Latency: event edge to redirect_valid = 1 cycle.
//  CSR writes: in IDLE, id_valid & csrWriteEnable & !event & !stall, committed at edge.
//   Trap/mret same cycle wins; CSR write dropped. mepc bits[1:0] written as 0; mtvec
//   bits[1:0] forced 0. mstatus writable bits: MIE[3], MPIE[7], MPP[12:11];
//   MPP write of 01/10 stored as 00; others read 0.
//  Unimplemented address: write ignored, csr_rdata=0. Addresses: mstatus 300, mtvec 305,
//   mscratch 340, mepc 341, mcause 342, mtval 343.
//  coprocessorStall high: FSM, counter, CSRs, privMode hold; redirect_valid/flush forced 0
//   and re-asserted for one cycle once stall drops (redirect not lost).
//  reset_n low mid-sequence: immediate return to reset values; pending redirect discarded.
// CONFIGURATION
//  TRAP_MTVAL_EN defined: mtval (343) implemented; on trap mtval<= {32'b0,id_instr} for
//   illegal, id_pc for ebreak, 0 for ecall; software-writable.
//  TRAP_MTVAL_EN undefined: mtval reads 0, writes ignored, no storage.
// TESTING
//  ecall in M, id_pc=0x100, mtvec=0x800 -> next cycle redirect_valid=1, flush=1,
//   redirect_pc=0x800; mcause=11, mepc=0x100, MPP=11, MIE=0.
//  mret after above with MPP=00 -> redirect_pc=0x100, privMode=00; then ecall -> mcause=8.
//  mret in U mode, instr 0x30200073 -> treated as illegal: mcause=2;
//   mtval=0x30200073 if TRAP_MTVAL_EN, else mtval reads 0.
//  CSR write mtvec=0x803 -> reads 0x800; same-cycle illegal + csrWriteEnable -> mtvec unchanged.
//  stall high the cycle after ecall for 3 cycles -> no redirect during stall; single
//   redirect pulse the cycle stall drops.
//  ebreak followed by illegal in DRAIN (DRAIN_CYCLES=2) -> second ignored, mcause stays 3;
//   reset_n low in REDIRECT -> all outputs 0, privMode=11.

Source files
------------

// File: rtl/trap_unit.sv
// Machine-mode trap/CSR controller: sequences trap entry and mret, owns the M-mode CSRs.
// Optional mtval storage is enabled by defining TRAP_MTVAL_EN.
module trap_unit #(
  parameter int               XLEN         = 64,
  parameter logic [XLEN-1:0]  RESET_MTVEC  = '0,
  parameter int               DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            coprocessorStall,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [31:0]     id_instr,
  input  logic [2:0]      exceptSignal,
  input  logic            trapReturn,
  input  logic            csrWriteEnable,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic [1:0]      privMode,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush
);

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_drain_cnt;
  logic [1:0]      r_priv;
  logic            r_mie, r_mpie;
  logic [1:0]      r_mpp;
  logic [XLEN-1:0] r_mtvec, r_mepc, r_mcause, r_mscratch, r_redirect_pc;

  logic            w_event, w_take, w_priv_m, w_is_mret, w_csr_we;
  logic [XLEN-1:0] w_cause;

  assign w_priv_m  = (r_priv == 2'b11);
  assign w_event   = id_valid & ((|exceptSignal) | trapReturn);
  assign w_take    = (r_state == S_IDLE) & ~coprocessorStall & w_event;
  // mret only counts as a return when nothing higher-priority fired and we are in M.
  assign w_is_mret = trapReturn & w_priv_m & ~(|exceptSignal);
  assign w_csr_we  = (r_state == S_IDLE) & id_valid & csrWriteEnable & ~w_event & ~coprocessorStall;

  always_comb begin
    w_cause = '0;
    if (exceptSignal[2])      w_cause = XLEN'(2);
    else if (exceptSignal[1]) w_cause = w_priv_m ? XLEN'(11) : XLEN'(8);
    else if (exceptSignal[0]) w_cause = XLEN'(3);
    else                      w_cause = XLEN'(2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (r_state)
      S_IDLE:     if (w_take) w_state_nxt = S_REDIRECT;
      S_REDIRECT: if (!coprocessorStall) begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        w_state_nxt    = S_DRAIN;
      end
      S_DRAIN:    if (!coprocessorStall && r_drain_cnt <= 4'd1) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drain_cnt <= '0;
    end else if (!coprocessorStall) begin
      if (r_state == S_REDIRECT)                      r_drain_cnt <= 4'(DRAIN_CYCLES);
      else if (r_state == S_DRAIN && r_drain_cnt != 0) r_drain_cnt <= r_drain_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_priv        <= 2'b11;
      r_mie         <= 1'b0;
      r_mpie        <= 1'b0;
      r_mpp         <= 2'b00;
      r_mtvec       <= {RESET_MTVEC[XLEN-1:2], 2'b00};
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mscratch    <= '0;
      r_redirect_pc <= '0;
    end else if (w_take) begin
      if (w_is_mret) begin
        r_priv        <= r_mpp;
        r_mie         <= r_mpie;
        r_mpie        <= 1'b1;
        r_mpp         <= 2'b00;
        r_redirect_pc <= r_mepc;
      end else begin
        r_mepc        <= {id_pc[XLEN-1:2], 2'b00};
        r_mcause      <= w_cause;
        r_mpie        <= r_mie;
        r_mie         <= 1'b0;
        r_mpp         <= r_priv;
        r_priv        <= 2'b11;
        r_redirect_pc <= {r_mtvec[XLEN-1:2], 2'b00};
      end
    end else if (w_csr_we) begin
      case (csr_addr)
        12'h300: begin
          r_mie  <= csr_wdata[3];
          r_mpie <= csr_wdata[7];
          r_mpp  <= (csr_wdata[12:11] == 2'b11) ? 2'b11 : 2'b00;
        end
        12'h305: r_mtvec    <= {csr_wdata[XLEN-1:2], 2'b00};
        12'h340: r_mscratch <= csr_wdata;
        12'h341: r_mepc     <= {csr_wdata[XLEN-1:2], 2'b00};
        12'h342: r_mcause   <= csr_wdata;
        default: ;
      endcase
    end
  end

`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] r_mtval;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mtval <= '0;
    end else if (w_take && !w_is_mret) begin
      if (exceptSignal[2] || !(exceptSignal[1] || exceptSignal[0]))
        r_mtval <= {{(XLEN-32){1'b0}}, id_instr};
      else if (exceptSignal[1])
        r_mtval <= '0;
      else
        r_mtval <= id_pc;
    end else if (w_csr_we && csr_addr == 12'h343) begin
      r_mtval <= csr_wdata;
    end
  end
`else
  logic w_unused_instr;
  assign w_unused_instr = ^id_instr;
`endif

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'h300: begin
        csr_rdata[3]     = r_mie;
        csr_rdata[7]     = r_mpie;
        csr_rdata[12:11] = r_mpp;
      end
      12'h305: csr_rdata = r_mtvec;
      12'h340: csr_rdata = r_mscratch;
      12'h341: csr_rdata = r_mepc;
      12'h342: csr_rdata = r_mcause;
`ifdef TRAP_MTVAL_EN
      12'h343: csr_rdata = r_mtval;
`endif
      default: csr_rdata = '0;
    endcase
  end

  assign privMode    = r_priv;
  assign redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_trap_unit.sv
// Self-checking bench for trap_unit: CSR write/readback table plus trap, mret, stall,
// drain and reset sequences with hand-computed expectations.
module tb_trap_unit;

  localparam int XLEN = 64;
`ifdef TRAP_MTVAL_EN
  localparam bit MTVAL_EN = 1'b1;
`else
  localparam bit MTVAL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            coprocessorStall;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic [2:0]      exceptSignal;
  logic            trapReturn;
  logic            csrWriteEnable;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic [1:0]      privMode;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;

  int n_tests = 0;
  int n_fail  = 0;

  trap_unit #(.XLEN(XLEN), .RESET_MTVEC('0), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .coprocessorStall(coprocessorStall),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .exceptSignal(exceptSignal), .trapReturn(trapReturn),
    .csrWriteEnable(csrWriteEnable), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .privMode(privMode), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [XLEN-1:0] d);
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [XLEN-1:0] d);
    @(negedge clk);
    id_valid = 1'b1; csrWriteEnable = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    id_valid = 1'b0; csrWriteEnable = 1'b0;
  endtask

  // Presents one event for a single cycle; returns at the negedge of the redirect cycle.
  task automatic fire(input logic [XLEN-1:0] pc, input logic [2:0] exc, input logic ret,
                      input logic [31:0] instr);
    @(negedge clk);
    id_valid = 1'b1; id_pc = pc; exceptSignal = exc; trapReturn = ret; id_instr = instr;
    @(negedge clk);
    id_valid = 1'b0; exceptSignal = '0; trapReturn = 1'b0; csrWriteEnable = 1'b0;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [XLEN-1:0] d;

  initial begin
    reset_n = 1'b0; coprocessorStall = 1'b0; id_valid = 1'b0; id_pc = '0; id_instr = '0;
    exceptSignal = '0; trapReturn = 1'b0; csrWriteEnable = 1'b0; csr_addr = '0; csr_wdata = '0;

    vecs[0] = '{12'h305, 64'h803,                   64'h800};
    vecs[1] = '{12'h340, 64'hDEADBEEF_12345678,     64'hDEADBEEF_12345678};
    vecs[2] = '{12'h341, 64'h107,                   64'h104};
    vecs[3] = '{12'h342, 64'h5,                     64'h5};
    vecs[4] = '{12'h300, 64'h1888,                  64'h1888};
    vecs[5] = '{12'h300, 64'hFFFF_FFFF_FFFF_FFFF,   64'h1888};
    vecs[6] = '{12'h300, 64'h0800,                  64'h0};
    vecs[7] = '{12'h300, 64'h1000,                  64'h0};
    vecs[8] = '{12'h344, 64'h1234,                  64'h0};
    vecs[9] = '{12'h343, 64'h55,                    MTVAL_EN ? 64'h55 : 64'h0};

    idle_cycles(2);
    reset_n = 1'b1;
    idle_cycles(1);

    check("reset_priv", 64'(privMode), 64'h3);
    check("reset_rv", 64'(redirect_valid), 64'h0);
    check("reset_flush", 64'(flush), 64'h0);
    check("reset_rpc", redirect_pc, 64'h0);
    csr_read(12'h305, d); check("reset_mtvec", d, 64'h0);
    csr_read(12'h300, d); check("reset_mstatus", d, 64'h0);

    for (int i = 0; i < 10; i++) begin
      csr_write(vecs[i].addr, vecs[i].wdata);
      csr_read(vecs[i].addr, d);
      check($sformatf("csr_vec%0d", i), d, vecs[i].exp);
    end

    // ecall in M mode
    fire(64'h100, 3'b010, 1'b0, 32'h00000073);
    check("ecallM_rv", 64'(redirect_valid), 64'h1);
    check("ecallM_flush", 64'(flush), 64'h1);
    check("ecallM_rpc", redirect_pc, 64'h800);
    csr_read(12'h342, d); check("ecallM_mcause", d, 64'd11);
    csr_read(12'h341, d); check("ecallM_mepc", d, 64'h100);
    csr_read(12'h300, d); check("ecallM_mstatus", d, 64'h1800);
    idle_cycles(1);
    check("ecallM_pulse_end", 64'(redirect_valid), 64'h0);
    idle_cycles(3);

    // mret back to U, then ecall from U
    csr_write(12'h300, 64'h0);
    fire(64'h180, 3'b000, 1'b1, 32'h30200073);
    check("mret_rv", 64'(redirect_valid), 64'h1);
    check("mret_rpc", redirect_pc, 64'h100);
    check("mret_priv", 64'(privMode), 64'h0);
    csr_read(12'h300, d); check("mret_mstatus", d, 64'h80);
    idle_cycles(4);
    fire(64'h200, 3'b010, 1'b0, 32'h00000073);
    csr_read(12'h342, d); check("ecallU_mcause", d, 64'd8);
    check("ecallU_priv", 64'(privMode), 64'h3);
    csr_read(12'h300, d); check("ecallU_mstatus", d, 64'h0);
    idle_cycles(4);

    // return to U, then mret from U is illegal
    fire(64'h280, 3'b000, 1'b1, 32'h30200073);
    check("mret2_rpc", redirect_pc, 64'h200);
    idle_cycles(4);
    check("mret2_priv", 64'(privMode), 64'h0);
    fire(64'h300, 3'b000, 1'b1, 32'h30200073);
    check("mretU_rv", 64'(redirect_valid), 64'h1);
    check("mretU_rpc", redirect_pc, 64'h800);
    csr_read(12'h342, d); check("mretU_mcause", d, 64'd2);
    csr_read(12'h341, d); check("mretU_mepc", d, 64'h300);
    csr_read(12'h343, d); check("mretU_mtval", d, MTVAL_EN ? 64'h30200073 : 64'h0);
    check("mretU_priv", 64'(privMode), 64'h3);
    idle_cycles(4);

    // illegal with a simultaneous CSR write: write must be dropped
    csrWriteEnable = 1'b1; csr_addr = 12'h305; csr_wdata = 64'h900;
    fire(64'h340, 3'b100, 1'b0, 32'hFFFFFFFF);
    csr_read(12'h305, d); check("illeg_we_mtvec", d, 64'h800);
    csr_read(12'h342, d); check("illeg_we_mcause", d, 64'd2);
    idle_cycles(4);

    // stall for 3 cycles following the ecall
    @(negedge clk);
    id_valid = 1'b1; id_pc = 64'h400; exceptSignal = 3'b010;
    @(negedge clk);
    id_valid = 1'b0; exceptSignal = '0; coprocessorStall = 1'b1;
    #1;
    check("stall_rv0", 64'(redirect_valid), 64'h0);
    check("stall_flush0", 64'(flush), 64'h0);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("stall_rv%0d", k), 64'(redirect_valid), 64'h0);
    end
    @(negedge clk);
    coprocessorStall = 1'b0;
    #1;
    check("stall_rel_rv", 64'(redirect_valid), 64'h1);
    check("stall_rel_flush", 64'(flush), 64'h1);
    check("stall_rel_rpc", redirect_pc, 64'h800);
    @(negedge clk); #1;
    check("stall_rel_pulse_end", 64'(redirect_valid), 64'h0);
    csr_read(12'h341, d); check("stall_mepc", d, 64'h400);
    idle_cycles(4);

    // ebreak, then illegal presented during DRAIN must be ignored
    fire(64'h500, 3'b001, 1'b0, 32'h00100073);
    check("ebrk_rv", 64'(redirect_valid), 64'h1);
    @(negedge clk);
    id_valid = 1'b1; id_pc = 64'h600; exceptSignal = 3'b100; id_instr = 32'hBAD0BAD0;
    #1;
    check("drain_rv_a", 64'(redirect_valid), 64'h0);
    @(negedge clk);
    id_valid = 1'b0; exceptSignal = '0;
    #1;
    check("drain_rv_b", 64'(redirect_valid), 64'h0);
    @(negedge clk); #1;
    check("drain_rv_c", 64'(redirect_valid), 64'h0);
    csr_read(12'h342, d); check("drain_mcause", d, 64'd3);
    csr_read(12'h341, d); check("drain_mepc", d, 64'h500);
    csr_read(12'h343, d); check("ebrk_mtval", d, MTVAL_EN ? 64'h500 : 64'h0);
    idle_cycles(3);

    // reset asserted while in REDIRECT
    fire(64'h700, 3'b010, 1'b0, 32'h00000073);
    check("prerst_rv", 64'(redirect_valid), 64'h1);
    reset_n = 1'b0;
    #1;
    check("rst_rv", 64'(redirect_valid), 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_rpc", redirect_pc, 64'h0);
    check("rst_priv", 64'(privMode), 64'h3);
    csr_read(12'h342, d); check("rst_mcause", d, 64'h0);
    csr_read(12'h305, d); check("rst_mtvec", d, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("postrst_rv%0d", k), 64'(redirect_valid), 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
